multicycle_control: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. It is the producer of the 2-bit ALUOp code that the ALU control decoder consumes: 00 means add, 01 means subtract, 10 means decode funct.
It sequences fetch, decode, execute, memory and writeback. It raises all datapath strobes and mux selects from the opcode and the current state.
Memory accesses use a ready handshake so a slow memory can stretch any access cycle.

---
 rtl/multicycle_control.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for the multi-cycle MIPS datapath. It walks each
// instruction through fetch, decode, execute, memory and writeback. It drives
// every datapath strobe and mux select from the current state, the opcode and
// the memory ready handshake. It also produces the 2-bit ALUOp code for the
// ALU control decoder:
//   00 = add
//   01 = subtract
//   10 = decode the funct field
//
// Parameters
//   MEM_WAIT_EN   1: the memory states (FETCH, MEMREAD, MEMWRITE) wait for
//                    MemReady.
//                 0: MemReady is ignored and treated as always 1.
//
// Ports
//   Clk          rising-edge clock
//   RstN         asynchronous active-low reset; forces FETCH
//   Opcode[5:0]  IR[31:26]; only looked at in DECODE and MEMADDR
//   MemReady     memory completed the current access this cycle
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load qualified by ALU Zero (beq)
//   IorD         memory address select: 0 = PC, 1 = ALUOut
//   MemRead      memory read strobe
//   MemWrite     memory write strobe
//   IRWrite      instruction register load
//   MemtoReg     writeback data select: 1 = MDR, 0 = ALUOut
//   RegDst       destination register select: 1 = rd, 0 = rt
//   RegWrite     register file write
//   ALUSrcA      ALU A select: 0 = PC, 1 = A
//   ALUSrcB[1:0] ALU B select:
//                  00 = B
//                  01 = 4
//                  10 = sign-extended imm
//                  11 = sign-extended imm << 2
//   ALUOp[1:0]   ALU operation code
//   PCSource[1:0] next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target
//   IllegalOp    high in DECODE when the opcode is unsupported
//   State[3:0]   current state (debug)
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       Clk,
    input  logic       RstN,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);

    // State encoding (visible on the State debug port)
    localparam logic [3:0] st_fetch    = 4'd0;
    localparam logic [3:0] st_decode   = 4'd1;
    localparam logic [3:0] st_memaddr  = 4'd2;
    localparam logic [3:0] st_memread  = 4'd3;
    localparam logic [3:0] st_memwb    = 4'd4;
    localparam logic [3:0] st_memwrite = 4'd5;
    localparam logic [3:0] st_execute  = 4'd6;
    localparam logic [3:0] st_rtypewb  = 4'd7;
    localparam logic [3:0] st_branch   = 4'd8;
    localparam logic [3:0] st_jump     = 4'd9;
    localparam logic [3:0] st_addiex   = 4'd10;
    localparam logic [3:0] st_addiwb   = 4'd11;

    // Supported opcodes
    localparam logic [5:0] op_rtype = 6'b000000;
    localparam logic [5:0] op_lw    = 6'b100011;
    localparam logic [5:0] op_sw    = 6'b101011;
    localparam logic [5:0] op_beq   = 6'b000100;
    localparam logic [5:0] op_j     = 6'b000010;
    localparam logic [5:0] op_addi  = 6'b001000;

    // ALUOp codes
    localparam logic [1:0] aluop_add   = 2'b00;
    localparam logic [1:0] aluop_sub   = 2'b01;
    localparam logic [1:0] aluop_funct = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] srcb_reg    = 2'b00;
    localparam logic [1:0] srcb_four   = 2'b01;
    localparam logic [1:0] srcb_imm    = 2'b10;
    localparam logic [1:0] srcb_imm_sh = 2'b11;

    // PCSource selects
    localparam logic [1:0] pcsrc_alu    = 2'b00;
    localparam logic [1:0] pcsrc_aluout = 2'b01;
    localparam logic [1:0] pcsrc_jump   = 2'b10;

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic       mem_ready;
    logic       fetch_done;

    // Without wait support the handshake collapses to "always ready".
    // The OR form keeps MemReady in use for both settings of the parameter.
    assign mem_ready = MemReady | ~MEM_WAIT_EN;

    // The fetch write strobes (IRWrite, PCWrite) come straight from
    // combinational logic. Qualifying them with RstN guarantees that no
    // write is issued while reset is held, even if memory reports ready.
    assign fetch_done = mem_ready & RstN;

    assign State = state_reg;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_reg <= st_fetch;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = st_fetch;
        case (state_reg)
            st_fetch: begin
                state_next = mem_ready ? st_decode : st_fetch;
            end

            st_decode: begin
                case (Opcode)
                    op_rtype: state_next = st_execute;
                    op_lw:    state_next = st_memaddr;
                    op_sw:    state_next = st_memaddr;
                    op_beq:   state_next = st_branch;
                    op_j:     state_next = st_jump;
                    op_addi:  state_next = st_addiex;
                    default:  state_next = st_fetch;
                endcase
            end

            // Opcode is sampled again here to split loads from stores.
            // Anything else (opcode changed since DECODE) retires to FETCH.
            st_memaddr: begin
                if (Opcode == op_lw) begin
                    state_next = st_memread;
                end else if (Opcode == op_sw) begin
                    state_next = st_memwrite;
                end else begin
                    state_next = st_fetch;
                end
            end

            st_memread: begin
                state_next = mem_ready ? st_memwb : st_memread;
            end

            st_memwrite: begin
                state_next = mem_ready ? st_fetch : st_memwrite;
            end

            st_execute: state_next = st_rtypewb;
            st_addiex:  state_next = st_addiwb;

            st_memwb,
            st_rtypewb,
            st_branch,
            st_jump,
            st_addiwb:  state_next = st_fetch;

            // Codes 12-15 are unreachable; recover to FETCH.
            default:    state_next = st_fetch;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (Moore, except the MemReady-qualified FETCH strobes)
    // ------------------------------------------------------------------
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = srcb_reg;
        ALUOp       = aluop_add;
        PCSource    = pcsrc_alu;
        IllegalOp   = 1'b0;

        case (state_reg)
            // Read the instruction at PC and compute PC + 4 in parallel.
            // The IR and PC loads happen only on the cycle the read completes.
            st_fetch: begin
                MemRead  = 1'b1;
                ALUSrcB  = srcb_four;
                ALUOp    = aluop_add;
                IRWrite  = fetch_done;
                PCWrite  = fetch_done;
                PCSource = pcsrc_alu;
            end

            // Speculatively compute the branch target, PC + (imm << 2).
            st_decode: begin
                ALUSrcB = srcb_imm_sh;
                ALUOp   = aluop_add;
                case (Opcode)
                    op_rtype, op_lw, op_sw, op_beq, op_j, op_addi:
                        IllegalOp = 1'b0;
                    default:
                        IllegalOp = 1'b1;
                endcase
            end

            st_memaddr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = srcb_imm;
                ALUOp   = aluop_add;
            end

            st_memread: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end

            st_memwb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                RegDst   = 1'b0;
            end

            // The write strobe is held through every wait cycle.
            st_memwrite: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end

            st_execute: begin
                ALUSrcA = 1'b1;
                ALUSrcB = srcb_reg;
                ALUOp   = aluop_funct;
            end

            st_rtypewb: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                MemtoReg = 1'b0;
            end

            // Subtract A - B. PC takes the branch target held in ALUOut
            // if Zero is set.
            st_branch: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = srcb_reg;
                ALUOp       = aluop_sub;
                PCWriteCond = 1'b1;
                PCSource    = pcsrc_aluout;
            end

            st_jump: begin
                PCWrite  = 1'b1;
                PCSource = pcsrc_jump;
            end

            st_addiex: begin
                ALUSrcA = 1'b1;
                ALUSrcB = srcb_imm;
                ALUOp   = aluop_add;
            end

            st_addiwb: begin
                RegWrite = 1'b1;
                RegDst   = 1'b0;
                MemtoReg = 1'b0;
            end

            default: begin
                // Unreachable codes keep every strobe low.
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control.
//
// The reference model works at the instruction level. Each opcode maps to
// the list of states the instruction visits. Memory states repeat while
// MemReady is held low. A per-state table gives the strobes expected in each
// visited state. Directed instructions run first, then randomized traffic
// with random opcodes, random wait cycles and random Opcode noise in the
// states that must ignore it.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic       Clk;
    logic       RstN;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int n_total = 0;
    int n_bad   = 0;

    multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
        .Clk         (Clk),
        .RstN        (RstN),
        .Opcode      (Opcode),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .IllegalOp   (IllegalOp),
        .State       (State)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // All outputs packed in a fixed order for one-shot comparison:
    // {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
    //  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp}
    logic [16:0] outs;
    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                   PCSource, IllegalOp};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, want);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] opc);
        return opc inside {6'b000000, 6'b100011, 6'b101011,
                           6'b000100, 6'b000010, 6'b001000};
    endfunction

    // Expected strobes for a state, taken from the state table.
    function automatic logic [16:0] exp_out(input int st, input bit rdy,
                                            input logic [5:0] opc);
        bit pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0;
        bit m2r = 0, rd = 0, rw = 0, asa = 0, ill = 0;
        logic [1:0] asb = 2'b00, aop = 2'b00, pcs = 2'b00;
        case (st)
            0:  begin mr = 1; asb = 2'b01; if (rdy) begin irw = 1; pcw = 1; end end
            1:  begin asb = 2'b11; ill = !is_legal(opc); end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa,
                asb, aop, pcs, ill};
    endfunction

    // One clock cycle: drive inputs just after the falling edge, check
    // slightly later, then advance to the next falling edge. Opcode carries
    // the instruction only where it is sampled; elsewhere it is noise.
    task automatic step(input int st, input bit rdy, input logic [5:0] opc);
        MemReady = rdy;
        Opcode   = (st == 1 || st == 2) ? opc : 6'($urandom);
        #1;
        chk($sformatf("state_s%0d", st), 32'(State), 32'(st));
        chk($sformatf("outs_s%0d", st), 32'(outs), 32'(exp_out(st, rdy, opc)));
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Run one instruction.
    // fw / mw: number of MemReady-low cycles in FETCH / in the data memory
    // state; -1 selects random waits (capped at 8 per access).
    task automatic run_instr(input logic [5:0] opc, input int fw, input int mw);
        int path[$];
        int cyc = 0;
        case (opc)
            6'b000000: path = '{0, 1, 6, 7};
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000100: path = '{0, 1, 8};
            6'b000010: path = '{0, 1, 9};
            6'b001000: path = '{0, 1, 10, 11};
            default:   path = '{0, 1};
        endcase
        foreach (path[k]) begin
            int s = path[k];
            if (s == 0 || s == 3 || s == 5) begin
                int w = (s == 0) ? fw : mw;
                int n = 0;
                bit rdy;
                do begin
                    if (w >= 0) rdy = (n >= w);
                    else        rdy = (n >= 8) || ($urandom_range(0, 9) >= 3);
                    step(s, rdy, opc);
                    cyc++;
                    n++;
                end while (!rdy);
            end else begin
                step(s, 1'($urandom_range(0, 1)), opc);
                cyc++;
            end
        end
        $display("instr opcode=%b cycles=%0d states=%0d", opc, cyc, path.size());
    endtask

    logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011,
                                  6'b000100, 6'b000010, 6'b001000};

    initial begin
        RstN     = 1'b1;
        MemReady = 1'b0;
        Opcode   = 6'b000000;
        #2 RstN = 1'b0;
        #1;
        chk("reset_state", 32'(State), 32'd0);
        chk("reset_outs", 32'(outs), 32'(exp_out(0, 1'b0, 6'b0)));
        @(negedge Clk);
        @(negedge Clk);
        RstN = 1'b1;

        // Directed instructions
        run_instr(6'b000000, 0, 0);   // add
        run_instr(6'b100011, 0, 2);   // lw with two memory wait cycles
        run_instr(6'b101011, 0, 0);   // sw
        run_instr(6'b000100, 0, 0);   // beq
        run_instr(6'b000010, 0, 0);   // j
        run_instr(6'b001000, 1, 0);   // addi
        run_instr(6'b111111, 3, 0);   // illegal, FETCH held three cycles
        run_instr(6'b101011, 0, 4);   // sw with waits

        // Reset in the middle of a stalled MEMWRITE
        step(0, 1'b1, 6'b101011);
        step(1, 1'b0, 6'b101011);
        step(2, 1'b0, 6'b101011);
        MemReady = 1'b0;
        Opcode   = 6'b101011;
        #1;
        chk("pre_rst_state", 32'(State), 32'd5);
        chk("pre_rst_memwrite", 32'(MemWrite), 32'd1);
        #1 RstN = 1'b0;
        #1;
        chk("midrst_state", 32'(State), 32'd0);
        chk("midrst_memwrite", 32'(MemWrite), 32'd0);
        chk("midrst_outs", 32'(outs), 32'(exp_out(0, 1'b0, 6'b0)));
        @(negedge Clk);
        RstN = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            logic [5:0] opc;
            int sel = $urandom_range(0, 6);
            if (sel < 6) begin
                opc = legal_ops[sel];
            end else begin
                do opc = 6'($urandom); while (is_legal(opc));
            end
            run_instr(opc, -1, -1);
        end

        MemReady = 1'b0;
        #1;
        chk("final_state", 32'(State), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
